// File: rtl/pattern_sequencer.sv
// Chooses which test pattern the generator shows: manual switch select, timed auto-cycling,
// or hold with single-step, all updated only on frame boundaries so a frame is never torn.
module pattern_sequencer #(
    parameter int   NUM_PATTERNS = 8,
    parameter int   DWELL_FRAMES = 60,
    parameter int   DB_CYCLES    = 250000,
    parameter logic VS_POL       = 1'b0
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        vSync,
    input  logic [9:0]  SW,
    input  logic        step,
    output logic [2:0]  patSel,
    output logic        frameTick,
    output logic        patChanged,
    output logic [15:0] frameCount,
    output logic [1:0]  seqState
);

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        AUTO   = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int          DB_W       = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [2:0]  LAST_PAT   = 3'(NUM_PATTERNS - 1);
    localparam logic [16:0] DWELL_END  = 17'(DWELL_FRAMES);

    state_t          state;
    logic            vs_r;
    logic            sync1;
    logic            sync2;
    logic            db_level;
    logic [DB_W-1:0] db_cnt;
    logic            db_rise;
    logic            step_pending;
    logic [15:0]     dwell;

    state_t          nxt_state;
    logic [2:0]      nxt_pat;
    logic [15:0]     nxt_dwell;
    logic [2:0]      adv_pat;
    logic [16:0]     dwell_inc;

    logic            unused_sw;
    assign unused_sw = &{1'b0, SW[7:3]};

    // Frame tick: one cycle after vSync first reaches its active level.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            vs_r      <= ~VS_POL;
            frameTick <= 1'b0;
        end else begin
            vs_r      <= vSync;
            frameTick <= (vSync == VS_POL) && (vs_r != VS_POL);
        end
    end

    assign db_rise = sync2 && !db_level && (db_cnt == DB_LAST);

    // Step button: synchronizer, counter debouncer, and a pending flag consumed per frame.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            db_level     <= 1'b0;
            db_cnt       <= '0;
            step_pending <= 1'b0;
        end else begin
            sync1 <= step;
            sync2 <= sync1;
            if (sync2 != db_level) begin
                if (db_cnt == DB_LAST) begin
                    db_level <= sync2;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
            // A press landing in the tick cycle itself is kept for the following frame.
            if (frameTick)
                step_pending <= db_rise;
            else if (db_rise)
                step_pending <= 1'b1;
        end
    end

    assign adv_pat   = (patSel == LAST_PAT) ? 3'd0 : patSel + 3'd1;
    assign dwell_inc = {1'b0, dwell} + 17'd1;

    always_comb begin
        nxt_state = MANUAL;
        nxt_pat   = patSel;
        nxt_dwell = dwell;
        if (!SW[9])
            nxt_state = MANUAL;
        else if (SW[8])
            nxt_state = HOLD;
        else
            nxt_state = AUTO;

        case (nxt_state)
            MANUAL: begin
                nxt_pat   = (SW[2:0] > LAST_PAT) ? LAST_PAT : SW[2:0];
                nxt_dwell = 16'd0;
            end
            AUTO: begin
                // Expiry and a pending step together still advance only once.
                if (dwell_inc >= DWELL_END || step_pending) begin
                    nxt_pat   = adv_pat;
                    nxt_dwell = 16'd0;
                end else begin
                    nxt_dwell = dwell_inc[15:0];
                end
            end
            HOLD: begin
                if (step_pending) begin
                    nxt_pat   = adv_pat;
                    nxt_dwell = 16'd0;
                end
            end
            default: begin
                nxt_pat   = patSel;
                nxt_dwell = dwell;
            end
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state      <= MANUAL;
            patSel     <= 3'd0;
            dwell      <= 16'd0;
            patChanged <= 1'b0;
            frameCount <= 16'd0;
        end else begin
            patChanged <= 1'b0;
            if (frameTick) begin
                state      <= nxt_state;
                patSel     <= nxt_pat;
                dwell      <= nxt_dwell;
                patChanged <= (nxt_pat != patSel);
                frameCount <= frameCount + 16'd1;
            end
        end
    end

    assign seqState = state;

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 Parameter NUM_PATTERNS, 8, number of selectable patterns (2..8).
REQ-002 Parameter DWELL_FRAMES, 60, frames each pattern is shown in auto mode (1..65535).
REQ-003 Parameter DB_CYCLES, 250000, stable cycles required to accept a step-button level change (>=1).
REQ-004 Parameter VS_POL, 0, active level of vSync.
REQ-005 clock  in  1  pixel clock; the single clock domain; all state on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 vSync  in  1  vertical sync from the timing controller, synchronous to clock.
REQ-008 SW  in  10  SW[2:0] manual pattern, SW[8] hold, SW[9] auto enable; others unused.
REQ-009 step  in  1  raw, asynchronous, active-high step button.
REQ-010 patSel  out  3  pattern select to the pattern generator.
REQ-011 frameTick  out  1  one-cycle pulse per frame.
REQ-012 patChanged  out  1  one-cycle pulse when patSel takes a new value.
REQ-013 frameCount  out  16  frames since reset, wraps 65535->0.
REQ-014 seqState  out  2  current state: 0 MANUAL, 1 AUTO, 2 HOLD.

Function
REQ-015 vSync SHALL be registered once; frameTick SHALL assert for exactly one cycle, in the cycle after the first cycle vSync equals VS_POL following a cycle where it did not.
REQ-016 patSel, seqState and the dwell counter SHALL change only in the frameTick cycle; patSel is therefore stable across every active frame.
REQ-017 frameCount SHALL increment by 1 in every frameTick cycle, modulo 2^16.
REQ-018 step SHALL pass a 2-flop synchronizer, then a debouncer whose output level changes only after the synchronized input differs from it for DB_CYCLES consecutive cycles.
REQ-019 A rising edge of the debounced level SHALL set stepPending; stepPending SHALL clear in the next frameTick cycle; multiple edges before a frameTick SHALL count as one.
REQ-020 In each frameTick cycle the next state SHALL be: SW[9]=0 -> MANUAL; SW[9]=1 and SW[8]=1 -> HOLD; SW[9]=1 and SW[8]=0 -> AUTO; the action at that tick is chosen by the next state.
REQ-021 MANUAL: patSel SHALL load min(SW[2:0], NUM_PATTERNS-1); stepPending is discarded; the dwell counter SHALL reset to 0.
REQ-022 AUTO: the dwell counter SHALL increment; when it reaches DWELL_FRAMES, or stepPending is set, patSel SHALL advance by one and the dwell counter SHALL reset to 0.
REQ-023 Dwell expiry and stepPending in the same tick SHALL advance patSel by exactly one.
REQ-024 HOLD: the dwell counter SHALL hold; stepPending SHALL advance patSel by one and reset the dwell counter to 0.
REQ-025 Advance SHALL wrap NUM_PATTERNS-1 -> 0.
REQ-026 Entering AUTO from MANUAL SHALL start dwell counting from 0, keeping the current patSel.
REQ-027 patChanged SHALL assert in the cycle after a frameTick cycle in which patSel's registered value changed; no pulse when the loaded value equals the old value.
REQ-028 SW SHALL be sampled only in frameTick cycles; SW changes between ticks have no effect.

Reset
REQ-029 While rst is high: patSel=0, frameTick=0, patChanged=0, frameCount=0, seqState=0 (MANUAL), dwell counter=0, stepPending=0, synchronizer and debouncer levels=0, registered vSync = inactive level.
REQ-030 Reset asserted mid-frame or mid-debounce SHALL discard all pending work; after release the first frameTick follows the next vSync assertion edge.
REQ-031 If vSync is already at VS_POL when rst deasserts, a frameTick SHALL occur one cycle after release.

Verification (NUM_PATTERNS=4, DWELL_FRAMES=3, DB_CYCLES=4, VS_POL=0)
REQ-032 SW[9]=0, SW[2:0]=6, 2 frames -> patSel=3 at first tick; patChanged once; seqState=0; frameCount=2.
REQ-033 SW[9]=1, SW[8]=0, 13 frames from patSel=0 -> patSel advances at ticks 3,6,9,12 giving 1,2,3,0 (wrap); four patChanged pulses.
REQ-034 AUTO, step high for 3 cycles then low -> no stepPending, no advance; step high 10 cycles -> exactly one advance at next tick, dwell restarts.
REQ-035 AUTO, step accepted so pending coincides with dwell expiry tick -> patSel+1 only; next advance 3 frames later.
REQ-036 SW[8]=1 (HOLD), 10 frames with no step -> patSel constant, seqState=2; one step -> single advance at next tick.
REQ-037 rst pulsed 2 cycles mid-frame with patSel=2, frameCount=5, pending step -> all outputs at reset values; no advance at next tick in MANUAL with SW[2:0]=0.
